// File: rtl/reg_pipe_hs.sv
// Elastic multi-slot pipeline register with valid/ready handshake.
// Bubbles collapse through a combinational ready chain. An optional one-entry
// skid buffer in front of slot 0 lets i_ready come straight from a flop.
// The global enable freezes all state. The synchronous clear flushes every entry.
module reg_pipe_hs #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned REG_READY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic                       sync_clr,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DW-1:0]              i_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [DW-1:0]              o_data,
  output logic [$clog2(DEPTH+2)-1:0] o_count,
  output logic                       o_full
);

  localparam int unsigned CW  = $clog2(DEPTH + 2);
  localparam int unsigned Cap = DEPTH + REG_READY;

  logic [DEPTH-1:0] vld_q, vld_d, rdy;
  logic [DW-1:0]    dat_q [DEPTH];
  logic [DW-1:0]    dat_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run, in_xfer, out_xfer;
  logic             src_vld;
  logic [DW-1:0]    src_dat;

  assign run      = enb & ~sync_clr;
  assign o_valid  = vld_q[DEPTH-1] & enb;
  assign o_data   = dat_q[DEPTH-1];
  assign out_xfer = o_valid & o_ready;
  assign in_xfer  = i_valid & i_ready;
  assign o_count  = cnt_q;
  assign o_full   = (cnt_q == CW'(Cap));

  // Ready chain: a slot can load if it is empty or everything below it moves.
  always_comb begin
    logic r;
    r                = o_ready | ~vld_q[DEPTH-1];
    rdy              = '0;
    rdy[DEPTH-1]     = r;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      r      = r | ~vld_q[k];
      rdy[k] = r;
    end
  end

  if (REG_READY != 0) begin : g_skid
    logic          sk_vld_q, sk_vld_d;
    logic [DW-1:0] sk_dat_q, sk_dat_d;
    logic          rdy_q, rdy_d;

    // Masked with enb so that no handshake completes while state is frozen.
    assign i_ready = rdy_q & enb;

    // Skid entry: catches a word slot 0 cannot take, and feeds slot 0 first.
    always_comb begin
      sk_vld_d = sk_vld_q;
      sk_dat_d = sk_dat_q;
      src_vld  = sk_vld_q | in_xfer;
      src_dat  = sk_vld_q ? sk_dat_q : i_data;
      if (sync_clr) begin
        sk_vld_d = 1'b0;
        sk_dat_d = '0;
      end else if (enb) begin
        if (rdy[0]) begin
          if (sk_vld_q) begin
            sk_vld_d = in_xfer;
            if (in_xfer) sk_dat_d = i_data;
          end
        end else if (in_xfer) begin
          sk_vld_d = 1'b1;
          sk_dat_d = i_data;
        end
      end
      rdy_d = run & ~sk_vld_d;
    end

    // Skid and registered-ready state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sk_vld_q <= 1'b0;
        sk_dat_q <= '0;
        rdy_q    <= 1'b0;
      end else begin
        sk_vld_q <= sk_vld_d;
        sk_dat_q <= sk_dat_d;
        rdy_q    <= rdy_d;
      end
    end
  end else begin : g_noskid
    assign i_ready = rst & run & rdy[0];
    assign src_vld = in_xfer;
    assign src_dat = i_data;
  end

  // Slot advance: each ready slot takes its source; data moves only with a valid.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (sync_clr) begin
      vld_d = '0;
      for (int k = 0; k < int'(DEPTH); k++) dat_d[k] = '0;
    end else if (enb) begin
      if (rdy[0]) begin
        vld_d[0] = src_vld;
        if (src_vld) dat_d[0] = src_dat;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy[k]) begin
          vld_d[k] = vld_q[k-1];
          if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
        end
      end
    end
  end

  // Occupancy counter across slots and skid.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr)  cnt_d = '0;
    else if (enb)  cnt_d = cnt_q + CW'(in_xfer) - CW'(out_xfer);
  end

  // Slot and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) dat_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
